elevator_motion_ctrl: RTL and testbench
=======================================

ELEVATOR_MOTION_CTRL -- requirements
Module: elevator_motion_ctrl

Interface
REQ-001 SHALL have parameter FLOOR_TICKS, default 8: clock cycles spent in MOVE per floor traversed (>=1).
REQ-002 SHALL have parameter DOOR_TICKS, default 4: clock cycles door_open stays high per stop (>=1).
REQ-003 SHALL have one clock, clk (input, 1): all state changes on rising edge.
REQ-004 SHALL have reset rst_n (input, 1): asynchronous, active-low.
REQ-005 SHALL have target_valid (input, 1): queue non-empty (tail != 0) from queue_logic's registered queue.
REQ-006 SHALL have target_lvl (input, 2): oldest queued floor (queue[1:0]); A=0, B=1, C=2, D=3.
REQ-007 SHALL have stop_at_pos_lvl (input, 1): from queue_logic, high when pos_lvl is in the queue.
REQ-008 SHALL have pos_lvl (output, 2, registered): current floor, fed back to queue_logic.pos_lvl.
REQ-009 SHALL have moving (output, 1): high in MOVE.
REQ-010 SHALL have dir_up (output, 1): travel direction latched for current MOVE; 1 = up.
REQ-011 SHALL have door_open (output, 1): high in DOOR.
REQ-012 SHALL have arrived (output, 1): one-cycle pulse on the cycle DOOR is entered.

Function
REQ-013 SHALL implement FSM states IDLE, MOVE, DOOR.
REQ-014 In IDLE, if stop_at_pos_lvl=1, SHALL go to DOOR (priority over moving).
REQ-015 In IDLE, else if target_valid=1 and target_lvl != pos_lvl, SHALL go to MOVE with dir_up = (target_lvl > pos_lvl).
REQ-016 In IDLE, otherwise (no target, or target_lvl == pos_lvl with stop low), SHALL remain IDLE.
REQ-017 In MOVE, floor counter SHALL count 0..FLOOR_TICKS-1; at terminal count pos_lvl SHALL step by +1 (dir_up) or -1, counter clear, state return to IDLE.
REQ-018 Each floor traversed therefore SHALL cost FLOOR_TICKS+1 cycles (MOVE phase plus one IDLE decision cycle).
REQ-019 The IDLE decision cycle after each step SHALL allow stops at intermediate floors present in the queue.
REQ-020 dir_up SHALL be sampled only on IDLE->MOVE; target_lvl/target_valid changes during MOVE SHALL be ignored until the next IDLE.
REQ-021 pos_lvl SHALL saturate: no decrement below A, no increment above D; a step that would cross a bound SHALL leave pos_lvl unchanged and return to IDLE.
REQ-022 In DOOR, door counter SHALL count 0..DOOR_TICKS-1; at terminal SHALL return to IDLE with counter cleared.
REQ-023 stop_at_pos_lvl SHALL be ignored in MOVE and DOOR.
REQ-024 arrived SHALL be high exactly on the first DOOR cycle; door_open high for exactly DOOR_TICKS cycles per stop.
REQ-025 moving and door_open SHALL never be high simultaneously.

Reset
REQ-026 On rst_n low, immediately and regardless of state: state=IDLE, pos_lvl=A, both counters 0, dir_up=0, moving=0, door_open=0, arrived=0.
REQ-027 Reset asserted mid-MOVE or mid-DOOR SHALL abandon the operation; no partial step completes after release.
REQ-028 First decision after rst_n release SHALL occur on the first rising edge with rst_n high.

Structure
REQ-029 Floor encodings A..D and FSM state encoding SHALL live in shared package elevator_pkg, also used by queue_logic benches.
REQ-030 Both timers SHALL be instances of one sub-module tick_timer (parameter MAX, inputs clk, rst_n, run; output done; counter width $clog2(MAX)).

Verification (FLOOR_TICKS=4, DOOR_TICKS=3)
REQ-031 Reset: rst_n=0 with arbitrary inputs -> pos_lvl=A, moving=0, door_open=0, arrived=0.
REQ-032 Full trip: pos A, target_valid=1, target_lvl=D, stop high only at D -> pos_lvl B/C/D at edges 5/10/15, arrived pulse and door_open at edge 16 for 3 cycles, IDLE at edge 19.
REQ-033 Intermediate stop: target D, stop_at_pos_lvl=1 when pos_lvl=C -> door opens at C for 3 cycles, then MOVE up resumes, reaches D.
REQ-034 Current-floor request: IDLE at B, stop_at_pos_lvl=1 -> door_open next edge, moving stays 0.
REQ-035 Mid-move target change: moving up from A, target_lvl changed to A during MOVE -> pos_lvl still reaches B, then IDLE sets dir_up=0 and returns to A.
REQ-036 Reset mid-move: rst_n low during MOVE at pos_lvl=C -> same cycle pos_lvl=A, moving=0, state IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared floor and motion-FSM encodings for the elevator controller and the queue_logic benches.
package elevator_pkg;

  typedef enum logic [1:0] {
    LVL_A = 2'd0,
    LVL_B = 2'd1,
    LVL_C = 2'd2,
    LVL_D = 2'd3
  } lvl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  localparam logic [1:0] LVL_BOTTOM = 2'd0;
  localparam logic [1:0] LVL_TOP    = 2'd3;

  // One-floor step that saturates at the shaft ends instead of wrapping.
  function automatic logic [1:0] step_lvl(input logic [1:0] lvl, input logic up);
    logic [1:0] nxt;
    nxt = lvl;
    if (up) begin
      if (lvl != LVL_TOP) nxt = lvl + 2'd1;
      else                nxt = lvl;
    end else begin
      if (lvl != LVL_BOTTOM) nxt = lvl - 2'd1;
      else                   nxt = lvl;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Phase timer: counts 0..MAX-1 while run is high, flags the terminal tick and wraps to zero.
module tick_timer #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic done
);

  localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] r_cnt;

  // Dropping run clears the count so every phase starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign done = run && (r_cnt == LAST);

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Elevator motion controller: steps one floor per MOVE phase and re-decides in IDLE after every
// floor so queued intermediate floors can be served on the way.
module elevator_motion_ctrl #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       target_valid,
  input  logic [1:0] target_lvl,
  input  logic       stop_at_pos_lvl,
  output logic [1:0] pos_lvl,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       arrived
);

  import elevator_pkg::*;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_pos;
  logic [1:0] w_pos_nxt;
  logic       r_dir;
  logic       w_dir_nxt;
  logic       r_moving;
  logic       r_door_open;
  logic       r_arrived;
  logic       w_move_run;
  logic       w_door_run;
  logic       w_floor_done;
  logic       w_door_done;

  assign w_move_run = (r_state == ST_MOVE);
  assign w_door_run = (r_state == ST_DOOR);

  tick_timer #(.MAX(FLOOR_TICKS)) u_floor_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_move_run),
    .done  (w_floor_done)
  );

  tick_timer #(.MAX(DOOR_TICKS)) u_door_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_door_run),
    .done  (w_door_done)
  );

  // A stop request at the current floor wins over starting a move; inputs are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (stop_at_pos_lvl) begin
          w_state_nxt = ST_DOOR;
        end else if (target_valid && (target_lvl != r_pos)) begin
          w_state_nxt = ST_MOVE;
          w_dir_nxt   = (target_lvl > r_pos);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (w_floor_done) begin
          w_state_nxt = ST_IDLE;
          w_pos_nxt   = step_lvl(r_pos, r_dir);
        end else begin
          w_state_nxt = ST_MOVE;
        end
      end
      ST_DOOR: begin
        if (w_door_done) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_DOOR;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pos       <= LVL_BOTTOM;
      r_dir       <= 1'b0;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_arrived   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_dir       <= w_dir_nxt;
      r_moving    <= (w_state_nxt == ST_MOVE);
      r_door_open <= (w_state_nxt == ST_DOOR);
      r_arrived   <= (w_state_nxt == ST_DOOR) && (r_state != ST_DOOR);
    end
  end

  assign pos_lvl   = r_pos;
  assign moving    = r_moving;
  assign dir_up    = r_dir;
  assign door_open = r_door_open;
  assign arrived   = r_arrived;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench for elevator_motion_ctrl (FLOOR_TICKS=4, DOOR_TICKS=3): stimulus pushes the
// expected event stream with hand-computed cycle stamps, a negedge monitor pops and compares.
module tb_elevator_motion_ctrl;

  import elevator_pkg::*;

  localparam int EV_STEP   = 0;
  localparam int EV_MSTART = 1;
  localparam int EV_ARRIVE = 2;
  localparam int EV_DEND   = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       target_valid;
  logic [1:0] target_lvl;
  logic       stop_at_pos_lvl;
  logic [1:0] pos_lvl;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic       arrived;
  logic [3:0] queue_mask;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  elevator_motion_ctrl #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .target_valid    (target_valid),
    .target_lvl      (target_lvl),
    .stop_at_pos_lvl (stop_at_pos_lvl),
    .pos_lvl         (pos_lvl),
    .moving          (moving),
    .dir_up          (dir_up),
    .door_open       (door_open),
    .arrived         (arrived)
  );

  // Stands in for queue_logic: stop is high whenever the current floor is queued.
  assign stop_at_pos_lvl = queue_mask[pos_lvl];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic string kname(input int k);
    case (k)
      EV_STEP:   return "step";
      EV_MSTART: return "move_start";
      EV_ARRIVE: return "arrive";
      EV_DEND:   return "door_end";
      default:   return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input int val);
    exp_t e;
    n_checks = n_checks + 1;
    if (exp_q.size() == 0) begin
      n_fail = n_fail + 1;
      $display("FAIL unexpected_%s: got val=%0d at cycle %0d, required no event", kname(kind), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %s val=%0d cycle=%0d, required %s val=%0d cycle=%0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: turns output changes into events and checks them against the scoreboard.
  initial begin
    logic [1:0] prev_pos;
    logic       prev_moving;
    logic       prev_door;
    int         door_len;
    prev_pos    = 2'd0;
    prev_moving = 1'b0;
    prev_door   = 1'b0;
    door_len    = 0;
    forever begin
      @(negedge clk);
      if (pos_lvl != prev_pos)      check_evt(EV_STEP, int'(pos_lvl));
      if (moving && !prev_moving)   check_evt(EV_MSTART, int'(dir_up));
      if (arrived)                  check_evt(EV_ARRIVE, int'(pos_lvl));
      if (!door_open && prev_door)  check_evt(EV_DEND, door_len);
      if (door_open) door_len = prev_door ? door_len + 1 : 1;
      check_val("moving_door_exclusive", int'(moving && door_open), 0);
      prev_pos    = pos_lvl;
      prev_moving = moving;
      prev_door   = door_open;
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    target_valid = 1'($urandom_range(0, 1));
    target_lvl   = 2'($urandom_range(0, 3));
    queue_mask   = 4'($urandom_range(0, 15));
    at_cyc(3);
    check_val("reset_pos_lvl", int'(pos_lvl), int'(LVL_A));
    check_val("reset_moving", int'(moving), 0);
    check_val("reset_door_open", int'(door_open), 0);
    check_val("reset_arrived", int'(arrived), 0);
    check_val("reset_dir_up", int'(dir_up), 0);

    // Full trip A->D; target presented together with reset release.
    t0 = cyc;
    rst_n = 1'b1; target_valid = 1'b1; target_lvl = LVL_D; queue_mask = 4'b1000;
    push(EV_MSTART, 1, t0 + 1);  push(EV_STEP, 1, t0 + 5);
    push(EV_MSTART, 1, t0 + 6);  push(EV_STEP, 2, t0 + 10);
    push(EV_MSTART, 1, t0 + 11); push(EV_STEP, 3, t0 + 15);
    push(EV_ARRIVE, 3, t0 + 16); push(EV_DEND, 3, t0 + 19);
    at_cyc(t0 + 17);
    queue_mask = 4'b0000; target_valid = 1'b0;
    at_cyc(t0 + 21);

    // Head down from D and reset mid-move at C.
    t0 = cyc;
    target_valid = 1'b1; target_lvl = LVL_A; queue_mask = 4'b0001;
    push(EV_MSTART, 0, t0 + 1); push(EV_STEP, 2, t0 + 5);
    push(EV_MSTART, 0, t0 + 6); push(EV_STEP, 0, t0 + 7);
    at_cyc(t0 + 7);
    rst_n = 1'b0; target_valid = 1'b0; queue_mask = 4'b0000;
    #1;
    check_val("midmove_reset_pos_lvl", int'(pos_lvl), int'(LVL_A));
    check_val("midmove_reset_moving", int'(moving), 0);
    check_val("midmove_reset_door_open", int'(door_open), 0);
    at_cyc(t0 + 9);
    rst_n = 1'b1;
    at_cyc(t0 + 13);

    // A->D with an intermediate stop at C.
    t0 = cyc;
    target_valid = 1'b1; target_lvl = LVL_D; queue_mask = 4'b1100;
    push(EV_MSTART, 1, t0 + 1);  push(EV_STEP, 1, t0 + 5);
    push(EV_MSTART, 1, t0 + 6);  push(EV_STEP, 2, t0 + 10);
    push(EV_ARRIVE, 2, t0 + 11); push(EV_DEND, 3, t0 + 14);
    push(EV_MSTART, 1, t0 + 15); push(EV_STEP, 3, t0 + 19);
    push(EV_ARRIVE, 3, t0 + 20); push(EV_DEND, 3, t0 + 23);
    at_cyc(t0 + 12);
    queue_mask = 4'b1000;
    at_cyc(t0 + 21);
    queue_mask = 4'b0000; target_valid = 1'b0;
    at_cyc(t0 + 25);

    // D->B, stop at B.
    t0 = cyc;
    target_valid = 1'b1; target_lvl = LVL_B; queue_mask = 4'b0010;
    push(EV_MSTART, 0, t0 + 1);  push(EV_STEP, 2, t0 + 5);
    push(EV_MSTART, 0, t0 + 6);  push(EV_STEP, 1, t0 + 10);
    push(EV_ARRIVE, 1, t0 + 11); push(EV_DEND, 3, t0 + 14);
    at_cyc(t0 + 12);
    queue_mask = 4'b0000; target_valid = 1'b0;
    at_cyc(t0 + 16);

    // Current-floor request at B beats a pending target at D.
    t0 = cyc;
    target_valid = 1'b1; target_lvl = LVL_D; queue_mask = 4'b0010;
    push(EV_ARRIVE, 1, t0 + 1); push(EV_DEND, 3, t0 + 4);
    at_cyc(t0 + 2);
    queue_mask = 4'b0000; target_valid = 1'b0;
    at_cyc(t0 + 6);

    // B->A, stop at A.
    t0 = cyc;
    target_valid = 1'b1; target_lvl = LVL_A; queue_mask = 4'b0001;
    push(EV_MSTART, 0, t0 + 1); push(EV_STEP, 0, t0 + 5);
    push(EV_ARRIVE, 0, t0 + 6); push(EV_DEND, 3, t0 + 9);
    at_cyc(t0 + 7);
    queue_mask = 4'b0000; target_valid = 1'b0;
    at_cyc(t0 + 11);

    // Target switched to A mid-move (stop at A high while moving away is ignored).
    t0 = cyc;
    target_valid = 1'b1; target_lvl = LVL_D; queue_mask = 4'b0000;
    push(EV_MSTART, 1, t0 + 1);  push(EV_STEP, 1, t0 + 5);
    push(EV_MSTART, 0, t0 + 6);  push(EV_STEP, 0, t0 + 10);
    push(EV_ARRIVE, 0, t0 + 11); push(EV_DEND, 3, t0 + 14);
    at_cyc(t0 + 2);
    target_lvl = LVL_A; queue_mask = 4'b0001;
    at_cyc(t0 + 12);
    queue_mask = 4'b0000; target_valid = 1'b0;
    at_cyc(t0 + 18);

    check_val("pending_expected_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
